// File: rtl/fft_spectrum_display_pkg.sv
// Shared constants, fill-state encoding and height/peak helpers for the FFT spectrum display.
// Optional peak-hold marker feature is enabled with PEAK_HOLD_EN.
package fft_spectrum_display_pkg;

    localparam int POINTS = 512;
    localparam int AW     = $clog2(POINTS);
    localparam int HW     = 9;
    localparam int H_DISP = 800;
    localparam int V_DISP = 480;
    localparam int SHIFT  = 6;

    localparam logic [15:0]   BAR_CLR = 16'hFFE0;
    localparam logic [15:0]   BG_CLR  = 16'h0000;
    localparam logic [15:0]   PK_CLR  = 16'hF800;
    localparam logic [HW-1:0] H_MAX   = 9'(V_DISP - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAP  = 3'd3,
        ST_FULL = 3'd4
    } fill_state_t;

    function automatic logic [HW-1:0] calc_height(input logic [15:0] mag);
        logic [15:0] scaled;
        scaled = mag >> SHIFT;
        if (scaled > 16'(H_MAX)) begin
            return H_MAX;
        end else begin
            return scaled[HW-1:0];
        end
    endfunction

    // Peak decays one line per frame but never drops below the newest height.
    function automatic logic [HW-1:0] peak_next(input logic [HW-1:0] old_pk,
                                                input logic [HW-1:0] new_h);
        logic [HW-1:0] dec;
        dec = (old_pk == 9'd0) ? 9'd0 : (old_pk - 9'd1);
        return (new_h > dec) ? new_h : dec;
    endfunction

endpackage

// File: rtl/fft_spectrum_display_if.sv
// FIFO handshake and LCD pixel bus of the spectrum display.
// master = FIFO/LCD-driver side, slave = the display block.
interface fft_spectrum_display_if;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_empty;
    logic        data_req;
    logic        fft_point_done;
    logic [15:0] pixel_data;

    modport master (
        output pixel_xpos, pixel_ypos, fifo_rd_data, fifo_rd_empty,
        input  data_req, fft_point_done, pixel_data
    );

    modport slave (
        input  pixel_xpos, pixel_ypos, fifo_rd_data, fifo_rd_empty,
        output data_req, fft_point_done, pixel_data
    );
endinterface

// File: rtl/fft_spectrum_display_spectrum_height_ram.sv
// Ping-pong bar-height store: 2*POINTS x 9 simple dual-port RAM with a registered read port.
module spectrum_height_ram
    import fft_spectrum_display_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW:0]   wr_addr,
    input  logic [HW-1:0] wr_data,
    input  logic [AW:0]   rd_addr,
    output logic [HW-1:0] rd_data
);

    logic [HW-1:0] mem_r [2*POINTS];
    logic [HW-1:0] rd_q_r;

    // fill-side write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // display-side registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q_r <= 9'd0;
        end else begin
            rd_q_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_q_r;

endmodule

// File: rtl/fft_spectrum_display.sv
// Pulls one spectrum frame from the FFT FIFO into a ping-pong height buffer and renders bars.
// Define PEAK_HOLD_EN to add decaying per-column peak markers.
module fft_spectrum_display
    import fft_spectrum_display_pkg::*;
(
    input  logic                          lcd_clk,
    input  logic                          rst_n,
    fft_spectrum_display_if.slave         bus
);

    fill_state_t   state_r;
    logic          wait_cnt_r;
    logic [AW-1:0] idx_r;
    logic          wr_bank_r;
    logic          disp_ok_r;
    logic          data_req_r;
    logic          point_done_r;
    logic          origin_d_r;

    logic          origin_s;
    logic          frame_start_s;
    logic          swap_s;
    logic          wr_en_s;
    logic [HW-1:0] height_s;
    logic [HW-1:0] height_q_s;

    logic          col_ok_d1_r;
    logic [10:0]   ypos_d1_r;
    logic [15:0]   pixel_data_r;
    logic [15:0]   pixel_next_s;
    logic [10:0]   bar_top_s;
    logic          peak_hit_s;

    assign origin_s      = (bus.pixel_xpos == 11'd0) && (bus.pixel_ypos == 11'd0);
    assign frame_start_s = origin_s && !origin_d_r;
    assign swap_s        = (state_r == ST_FULL) && frame_start_s;
    assign wr_en_s       = (state_r == ST_CAP);
    assign height_s      = calc_height(bus.fifo_rd_data);

    // frame-start edge detector: only the first cycle at the origin counts
    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            origin_d_r <= 1'b0;
        end else begin
            origin_d_r <= origin_s;
        end
    end

    // fill FSM: one FIFO word per pass, idx is the authoritative write address
    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= 1'b0;
            idx_r        <= 9'd0;
            wr_bank_r    <= 1'b0;
            disp_ok_r    <= 1'b0;
            data_req_r   <= 1'b0;
            point_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!bus.fifo_rd_empty) begin
                        state_r    <= ST_REQ;
                        data_req_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    data_req_r <= 1'b0;
                    wait_cnt_r <= 1'b0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt_r) begin
                        state_r      <= ST_CAP;
                        point_done_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= 1'b1;
                    end
                end
                ST_CAP: begin
                    point_done_r <= 1'b0;
                    if (idx_r == 9'(POINTS - 1)) begin
                        idx_r   <= 9'd0;
                        state_r <= ST_FULL;
                    end else begin
                        idx_r   <= idx_r + 9'd1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_FULL: begin
                    if (frame_start_s) begin
                        wr_bank_r <= ~wr_bank_r;
                        disp_ok_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    data_req_r   <= 1'b0;
                    point_done_r <= 1'b0;
                end
            endcase
        end
    end

    spectrum_height_ram u_ram (
        .clk     (lcd_clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s),
        .wr_addr ({wr_bank_r, idx_r}),
        .wr_data (height_s),
        .rd_addr ({~wr_bank_r, bus.pixel_xpos[AW-1:0]}),
        .rd_data (height_q_s)
    );

`ifdef PEAK_HOLD_EN
    logic [HW-1:0] pend_r [POINTS];
    logic [HW-1:0] peak_r [POINTS];
    logic [HW-1:0] peak_q_r;

    // heights of the frame being filled, folded into the peaks at swap time
    always_ff @(posedge lcd_clk) begin
        if (wr_en_s) begin
            pend_r[idx_r] <= height_s;
        end
    end

    // peak registers update on swap and are read alongside the height RAM
    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < POINTS; i++) begin
                peak_r[i] <= 9'd0;
            end
            peak_q_r <= 9'd0;
        end else begin
            if (swap_s) begin
                for (int i = 0; i < POINTS; i++) begin
                    peak_r[i] <= peak_next(peak_r[i], pend_r[i]);
                end
            end
            peak_q_r <= peak_r[bus.pixel_xpos[AW-1:0]];
        end
    end
`endif

    // first display stage, aligned with the RAM read
    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_ok_d1_r <= 1'b0;
            ypos_d1_r   <= 11'd0;
        end else begin
            col_ok_d1_r <= disp_ok_r && (bus.pixel_xpos < 11'(POINTS));
            ypos_d1_r   <= bus.pixel_ypos;
        end
    end

    // bar/peak/background decision
    always_comb begin
        bar_top_s    = 11'(V_DISP - 1) - {2'b00, height_q_s};
        peak_hit_s   = 1'b0;
        pixel_next_s = BG_CLR;
`ifdef PEAK_HOLD_EN
        peak_hit_s = (ypos_d1_r == (11'(V_DISP - 1) - {2'b00, peak_q_r}));
`endif
        if (!col_ok_d1_r) begin
            pixel_next_s = BG_CLR;
        end else if (peak_hit_s) begin
            pixel_next_s = PK_CLR;
        end else if (ypos_d1_r >= bar_top_s) begin
            pixel_next_s = BAR_CLR;
        end else begin
            pixel_next_s = BG_CLR;
        end
    end

    // registered pixel output
    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data_r <= BG_CLR;
        end else begin
            pixel_data_r <= pixel_next_s;
        end
    end

    assign bus.data_req       = data_req_r;
    assign bus.fft_point_done = point_done_r;
    assign bus.pixel_data     = pixel_data_r;

endmodule

// File: tb/tb_fft_spectrum_display.sv
// Randomized bench for fft_spectrum_display with a frame-level reference model.
module tb_fft_spectrum_display;
    import fft_spectrum_display_pkg::*;

    logic lcd_clk;
    logic rst_n;

    fft_spectrum_display_if bus ();

    fft_spectrum_display dut (
        .lcd_clk (lcd_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial begin
        lcd_clk = 1'b0;
        forever #5 lcd_clk = ~lcd_clk;
    end

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] inflight_q[$];
    logic [15:0] stage_w;
    bit          stage_v;
    int          req_cnt;
    int          done_cnt;

    int  back_m [POINTS];
    int  disp_m [POINTS];
    int  peak_m [POINTS];
    int  fill_idx_m;
    bit  full_m;
    bit  disp_ok_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int height_ref(input logic [15:0] w);
        int h;
        h = int'(w) / (1 << SHIFT);
        if (h > V_DISP - 1) h = V_DISP - 1;
        return h;
    endfunction

    function automatic logic [15:0] exp_pixel(input int x, input int y);
        if (x >= POINTS || !disp_ok_m) return BG_CLR;
`ifdef PEAK_HOLD_EN
        if (y == V_DISP - 1 - peak_m[x]) return PK_CLR;
`endif
        if (y >= V_DISP - 1 - disp_m[x]) return BAR_CLR;
        return BG_CLR;
    endfunction

    // FIFO model and fill-side scoreboard, all on the falling edge
    initial begin
        bus.fifo_rd_data  = 16'h0000;
        bus.fifo_rd_empty = 1'b1;
        stage_v = 1'b0;
        forever begin
            @(negedge lcd_clk);
            if (!rst_n) begin
                stage_v = 1'b0;
                inflight_q.delete();
            end else begin
                if (bus.fft_point_done) begin
                    logic [15:0] w;
                    w = (inflight_q.size() > 0) ? inflight_q.pop_front() : 16'h0000;
                    back_m[fill_idx_m] = height_ref(w);
                    fill_idx_m++;
                    done_cnt++;
                    if (fill_idx_m == POINTS) begin
                        fill_idx_m = 0;
                        full_m = 1'b1;
                    end
                end
                if (stage_v) begin
                    bus.fifo_rd_data = stage_w;
                    stage_v = 1'b0;
                end
                if (bus.data_req) begin
                    req_cnt++;
                    stage_w = (fifo_q.size() > 0) ? fifo_q.pop_front() : 16'h0000;
                    stage_v = 1'b1;
                    inflight_q.push_back(stage_w);
                    bus.fifo_rd_data = 16'($urandom);
                end
            end
            bus.fifo_rd_empty = (fifo_q.size() == 0);
        end
    end

    task automatic wait_done(input int target, input int budget);
        int c = 0;
        while (done_cnt < target && c < budget) begin
            @(negedge lcd_clk);
            c++;
        end
        repeat (2) @(negedge lcd_clk);
        check_eq("done_reached", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic frame_start();
        @(negedge lcd_clk);
        bus.pixel_xpos = 11'd0;
        bus.pixel_ypos = 11'd0;
        if (full_m) begin
            for (int i = 0; i < POINTS; i++) begin
                int p;
                p = (peak_m[i] > 0) ? peak_m[i] - 1 : 0;
                if (back_m[i] > p) p = back_m[i];
                peak_m[i] = p;
                disp_m[i] = back_m[i];
            end
            disp_ok_m = 1'b1;
            full_m = 1'b0;
        end
        @(negedge lcd_clk);
        bus.pixel_xpos = 11'd700;
        bus.pixel_ypos = 11'd5;
    endtask

    task automatic check_pixel(input string tag, input int x, input int y);
        @(negedge lcd_clk);
        bus.pixel_xpos = 11'(x);
        bus.pixel_ypos = 11'(y);
        @(negedge lcd_clk);
        @(negedge lcd_clk);
        check_eq(tag, 32'(bus.pixel_data), 32'(exp_pixel(x, y)));
    endtask

    task automatic check_random(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            int x;
            int y;
            x = $urandom_range(0, 599);
            y = $urandom_range(0, V_DISP - 1);
            if (x == 0 && y == 0) y = 1;
            if ((k % 3) == 0 && x < POINTS) y = V_DISP - 1 - disp_m[x] + $urandom_range(0, 2) - 1;
            if (y < 0) y = 0;
            if (y > V_DISP - 1) y = V_DISP - 1;
            check_pixel(tag, x, y);
        end
    endtask

    task automatic push_words(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            case (mode)
                0: w = 16'h0400;
                1: w = 16'hFFFF;
                2: w = 16'd6400;
                3: w = 16'h0000;
                default: begin
                    if ($urandom_range(0, 3) == 0) w = 16'(30600 + $urandom_range(0, 120));
                    else w = 16'($urandom);
                end
            endcase
            fifo_q.push_back(w);
        end
    endtask

    task automatic reset_model();
        fill_idx_m = 0;
        full_m     = 1'b0;
        disp_ok_m  = 1'b0;
        req_cnt    = 0;
        done_cnt   = 0;
        fifo_q.delete();
        for (int i = 0; i < POINTS; i++) begin
            back_m[i] = 0;
            disp_m[i] = 0;
            peak_m[i] = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pixel_xpos = 11'd700;
        bus.pixel_ypos = 11'd5;
        reset_model();
        repeat (3) @(negedge lcd_clk);
        check_eq("rst_data_req", 32'(bus.data_req), 32'd0);
        check_eq("rst_point_done", 32'(bus.fft_point_done), 32'd0);
        check_eq("rst_pixel", 32'(bus.pixel_data), 32'(BG_CLR));
        rst_n = 1'b1;

        // FIFO stays empty: no requests, nothing displayed
        repeat (50) @(negedge lcd_clk);
        check_eq("empty_no_req", 32'(req_cnt), 32'd0);
        check_pixel("empty_pix", 10, 479);

        // uniform frame of 0x0400 (height 16)
        push_words(POINTS, 0);
        wait_done(POINTS, 4000);
        check_eq("t1_req_cnt", 32'(req_cnt), 32'(POINTS));
        check_eq("t1_done_cnt", 32'(done_cnt), 32'(POINTS));
        check_pixel("t1_before_swap", 10, 479);
        frame_start();
        check_pixel("t1_c10_r479", 10, 479);
        check_pixel("t1_c10_r464", 10, 464);
        check_pixel("t1_c10_r463", 10, 463);
        check_pixel("t1_c10_r462", 10, 462);
        check_pixel("t1_c511_r479", 511, 479);
        check_pixel("t1_c512_r479", 512, 479);
        check_pixel("t1_c600_r479", 600, 479);

        // random frame with saturating and exact-boundary columns
        for (int i = 0; i < POINTS; i++) begin
            logic [15:0] w;
            if (i == 3 || i == 511) w = 16'hFFFF;
            else if (i == 7) w = 16'd6400;
            else if ($urandom_range(0, 3) == 0) w = 16'(30600 + $urandom_range(0, 120));
            else w = 16'($urandom);
            fifo_q.push_back(w);
        end
        wait_done(done_cnt + POINTS, 4000);
        frame_start();
        check_pixel("t2_sat_r0", 3, 0);
        check_pixel("t2_sat_r479", 3, 479);
        check_pixel("t2_sat_c511_r0", 511, 0);
        check_pixel("t2_h100_r379", 7, 379);
        check_pixel("t2_h100_r378", 7, 378);
        check_random("t2_rand", 30);

        // frame start mid-fill must not swap
        push_words(200, 4);
        wait_done(done_cnt + 200, 2000);
        frame_start();
        check_random("t4_midfill", 20);
        push_words(POINTS - 200, 4);
        wait_done(done_cnt + POINTS - 200, 4000);
        frame_start();
        check_random("t4_after", 20);

        // reset in the middle of a fill
        push_words(300, 4);
        wait_done(done_cnt + 300, 3000);
        check_pixel("t5_pre_rst", 10, 479);
        @(negedge lcd_clk);
        rst_n = 1'b0;
        reset_model();
        #1;
        check_eq("t5_rst_pixel", 32'(bus.pixel_data), 32'(BG_CLR));
        check_eq("t5_rst_req", 32'(bus.data_req), 32'd0);
        check_eq("t5_rst_done", 32'(bus.fft_point_done), 32'd0);
        repeat (3) @(negedge lcd_clk);
        rst_n = 1'b1;
        check_pixel("t5_post_rst", 10, 479);
        push_words(POINTS, 4);
        wait_done(POINTS, 4000);
        check_eq("t5_req_cnt", 32'(req_cnt), 32'(POINTS));
        frame_start();
        check_random("t5_refill", 20);

`ifdef PEAK_HOLD_EN
        push_words(POINTS, 2);
        wait_done(done_cnt + POINTS, 4000);
        frame_start();
        check_pixel("t6_pk379", 5, 379);
        check_eq("t6_pk379_const", 32'(bus.pixel_data), 32'(PK_CLR));
        for (int f = 1; f <= 2; f++) begin
            push_words(POINTS, 3);
            wait_done(done_cnt + POINTS, 4000);
            frame_start();
            check_pixel("t6_pk_decay", 5, 379 + f);
            check_eq("t6_pk_decay_const", 32'(bus.pixel_data), 32'(PK_CLR));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
